conv2d_window_feeder: RTL and testbench
=======================================

# conv2d_window_feeder

Transmit-side companion to the 2D square-input/square-kernel convolution core. Accepts a raster-order square image one pixel per handshake, buffers K rows, and serializes every valid KxK window as K*K consecutive 32-bit taps onto the core's `input_data` stream, with per-window and per-frame markers. Sits between the activation source and the convolution MAC; stride 1, no padding, single channel per pass.

## Interface
- `DATA_W`, 32: pixel/tap width in bits.
- `IMG_W`, 8: image side length (square input), >= K.
- `K`, 3: kernel side length (square kernel), >= 2.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `valid_in` in 1: source presents a pixel.
- `in_ready` out 1: feeder accepts the pixel this cycle.
- `input_data` in DATA_W: pixel, raster order, row 0 col 0 first.
- `valid_out` out 1: `output_data` holds a tap.
- `out_ready` in 1: conv core accepts the tap this cycle.
- `output_data` out DATA_W: current window tap.
- `tap_last` out 1: tap is the last (K*K-1) of its window.
- `frame_end` out 1: tap is the last tap of the last window of the frame.

## Operation
- Storage: row buffer of K*IMG_W words, address = slot*IMG_W + col; slot = row mod K (wrapping counter, not a divider). Contents not reset.
- Counters: `col` 0..IMG_W-1, `row` 0..IMG_W-1, `slot` 0..K-1, window tap `ky`,`kx` 0..K-1.
- FSM, two states:
  - FILL: `in_ready`=1. Accept on `valid_in && in_ready`: write pixel, advance col/row/slot. If accepted pixel has row >= K-1 and col >= K-1 (window complete) -> EMIT with window origin (row-K+1, col-K+1) latched; else stay.
  - EMIT: `in_ready`=0. Present tap (ky,kx) = pixel (origin_r+ky, origin_c+kx), ky outer, kx inner. Advance on `valid_out && out_ready`. After tap (K-1,K-1) accepted -> FILL.
- Row slot for tap ky = (origin slot + ky) mod K, computed by wrap-add without division.
- Overwrite safety: row r+1 pixels enter only after all row-r windows are emitted; no further hazard handling needed.
- Frame: after pixel (IMG_W-1, IMG_W-1) accepted, row/col/slot return to 0; `frame_end` asserted with `tap_last` on that frame's final window tap. Next frame accepted immediately after.
- Windows per frame: (IMG_W-K+1)^2; defaults 36 windows, 324 taps.

## Timing
- Reset (async assert): state FILL, counters 0, `valid_out`=0, `tap_last`=0, `frame_end`=0, `output_data`=0; `in_ready`=1 once `rst_n` high.
- Latency: completing pixel accepted in cycle t -> tap 0 valid in cycle t+1 (registered output). Taps then one per cycle with `out_ready` held high.
- Backpressure: while `valid_out && !out_ready`, `output_data`, `tap_last`, `frame_end` held stable.
- Throughput: one pixel/cycle in FILL; K*K cycles minimum per window; no overlap of accept and emit.
- `valid_in` ignored in EMIT (no accept).
- Reset mid-EMIT: tap sequence abandoned, `valid_out` drops asynchronously, next pixel accepted is treated as row 0 col 0.

## Configuration
- `CONV_WIN_STRIDE2_EN` defined: window emitted only when origin row and origin col are both even (stride 2); other completing pixels stay in FILL. Defaults: 9 windows, 81 taps per frame, `frame_end` on last tap of window origin (4,4).
- Undefined: stride 1 as described above.

## Test plan
- Pixels = row*8+col, `out_ready`=1, `valid_in`=1: first window taps 0,1,2,8,9,10,16,17,18; `tap_last` on 18; `in_ready` low 9 cycles after pixel 18 accepted.
- Same stimulus, full frame: exactly 36 windows / 324 taps; last window 45,46,47,53,54,55,61,62,63; `frame_end` only on tap 63.
- Random `out_ready` (50%) stall: tap stream identical to stalled-free run; outputs stable during every stall cycle.
- Two back-to-back frames (second = pixel+100): second frame first window 100,101,102,108,109,110,116,117,118; no stale first-frame data.
- Assert `rst_n` low during tap 4 of window 10: `valid_out`=0 immediately; after release, fresh frame yields first window 0,1,2,8,9,10,16,17,18.
- With `CONV_WIN_STRIDE2_EN`: 9 windows, origins (0,0),(0,2)...(4,4); second window taps 2,3,4,10,11,12,18,19,20.

Source files
------------

// File: rtl/conv2d_window_feeder.sv
// rtl/conv2d_window_feeder.sv - buffers K image rows and streams every KxK window as K*K taps.
// Define CONV_WIN_STRIDE2_EN to emit only windows whose origin row and col are both even.
module conv2d_window_feeder #(
  parameter int DATA_W = 32,
  parameter int IMG_W  = 8,
  parameter int K      = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  output logic              in_ready,
  input  logic [DATA_W-1:0] input_data,
  output logic              valid_out,
  input  logic              out_ready,
  output logic [DATA_W-1:0] output_data,
  output logic              tap_last,
  output logic              frame_end
);

  localparam int CW = $clog2(IMG_W);
  localparam int KW = (K > 2) ? $clog2(K) : 1;
  localparam int AW = $clog2(K * IMG_W);
`ifdef CONV_WIN_STRIDE2_EN
  localparam int LAST_ORG = ((IMG_W - K) / 2) * 2;
`else
  localparam int LAST_ORG = IMG_W - K;
`endif

  localparam logic ST_FILL = 1'b0;
  localparam logic ST_EMIT = 1'b1;

  logic              state_q, state_d;
  logic [CW-1:0]     col_q, col_d, row_q, row_d, org_c_q, org_c_d;
  logic [KW-1:0]     slot_q, slot_d, tap_slot_q, tap_slot_d, ky_q, ky_d, kx_q, kx_d;
  logic              frame_q, frame_d, valid_q, valid_d, last_q, last_d, fend_q, fend_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] buf_q [K*IMG_W];

  logic              accept, launch, win_done, last_col, last_row, last_slot, kx_last;
  logic [CW-1:0]     org_r, org_c, rd_col;
  logic [KW-1:0]     org_slot, nkx, nky, nslot, rd_slot;
  logic [AW-1:0]     rd_addr, wr_addr;
  logic [DATA_W-1:0] rd_data;

  assign accept    = (state_q == ST_FILL) && valid_in;
  assign last_col  = (col_q == CW'(IMG_W - 1));
  assign last_row  = (row_q == CW'(IMG_W - 1));
  assign last_slot = (slot_q == KW'(K - 1));
  assign org_r     = row_q - CW'(K - 1);
  assign org_c     = col_q - CW'(K - 1);
`ifdef CONV_WIN_STRIDE2_EN
  assign win_done  = (row_q >= CW'(K - 1)) && (col_q >= CW'(K - 1)) && !org_r[0] && !org_c[0];
`else
  assign win_done  = (row_q >= CW'(K - 1)) && (col_q >= CW'(K - 1));
`endif
  assign launch    = accept && win_done;

  // Origin row is K-1 rows back, which is one slot ahead modulo K.
  assign org_slot  = last_slot ? '0 : slot_q + KW'(1);

  assign kx_last   = (kx_q == KW'(K - 1));
  assign nkx       = kx_last ? '0 : kx_q + KW'(1);
  assign nky       = kx_last ? ky_q + KW'(1) : ky_q;
  assign nslot     = !kx_last ? tap_slot_q :
                     (tap_slot_q == KW'(K - 1)) ? '0 : tap_slot_q + KW'(1);

  assign rd_slot   = (state_q == ST_FILL) ? org_slot : nslot;
  assign rd_col    = (state_q == ST_FILL) ? org_c : org_c_q + CW'(nkx);
  assign rd_addr   = AW'(int'(rd_slot) * IMG_W + int'(rd_col));
  assign wr_addr   = AW'(int'(slot_q) * IMG_W + int'(col_q));
  assign rd_data   = buf_q[rd_addr];

  always_ff @(posedge clk) begin
    if (accept) buf_q[wr_addr] <= input_data;
  end

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    slot_d     = slot_q;
    org_c_d    = org_c_q;
    tap_slot_d = tap_slot_q;
    ky_d       = ky_q;
    kx_d       = kx_q;
    frame_d    = frame_q;
    valid_d    = valid_q;
    last_d     = last_q;
    fend_d     = fend_q;
    data_d     = data_q;
    if (state_q == ST_FILL) begin
      if (accept) begin
        col_d = last_col ? '0 : col_q + CW'(1);
        if (last_col) begin
          row_d  = last_row ? '0 : row_q + CW'(1);
          slot_d = (last_row || last_slot) ? '0 : slot_q + KW'(1);
        end
        if (launch) begin
          state_d    = ST_EMIT;
          org_c_d    = org_c;
          tap_slot_d = org_slot;
          ky_d       = '0;
          kx_d       = '0;
          frame_d    = (org_r == CW'(LAST_ORG)) && (org_c == CW'(LAST_ORG));
          valid_d    = 1'b1;
          last_d     = 1'b0;
          fend_d     = 1'b0;
          data_d     = rd_data;
        end
      end
    end else if (out_ready) begin
      if (last_q) begin
        state_d = ST_FILL;
        valid_d = 1'b0;
        last_d  = 1'b0;
        fend_d  = 1'b0;
      end else begin
        kx_d       = nkx;
        ky_d       = nky;
        tap_slot_d = nslot;
        data_d     = rd_data;
        last_d     = (nky == KW'(K - 1)) && (nkx == KW'(K - 1));
        fend_d     = (nky == KW'(K - 1)) && (nkx == KW'(K - 1)) && frame_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FILL;
      col_q      <= '0;
      row_q      <= '0;
      slot_q     <= '0;
      org_c_q    <= '0;
      tap_slot_q <= '0;
      ky_q       <= '0;
      kx_q       <= '0;
      frame_q    <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      fend_q     <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      slot_q     <= slot_d;
      org_c_q    <= org_c_d;
      tap_slot_q <= tap_slot_d;
      ky_q       <= ky_d;
      kx_q       <= kx_d;
      frame_q    <= frame_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      fend_q     <= fend_d;
      data_q     <= data_d;
    end
  end

  assign in_ready    = (state_q == ST_FILL);
  assign valid_out   = valid_q;
  assign output_data = data_q;
  assign tap_last    = last_q;
  assign frame_end   = fend_q;

endmodule

// File: tb/tb_conv2d_window_feeder.sv
// tb/tb_conv2d_window_feeder.sv - scoreboard bench for conv2d_window_feeder.
module tb_conv2d_window_feeder;
  localparam int DATA_W = 32;
  localparam int IMG_W  = 8;
  localparam int K      = 3;
  localparam int NW     = IMG_W - K + 1;
`ifdef CONV_WIN_STRIDE2_EN
  localparam int STEP   = 2;
`else
  localparam int STEP   = 1;
`endif
  localparam int NWS     = (NW - 1) / STEP + 1;
  localparam int WPF     = NWS * NWS;
  localparam int TPF     = WPF * K * K;
  localparam int RST_WIN = (WPF > 10) ? 10 : WPF - 2;

  logic              clk, rst_n, valid_in, in_ready, valid_out, out_ready, tap_last, frame_end;
  logic [DATA_W-1:0] input_data, output_data;

  conv2d_window_feeder #(.DATA_W(DATA_W), .IMG_W(IMG_W), .K(K)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .in_ready(in_ready),
    .input_data(input_data), .valid_out(valid_out), .out_ready(out_ready),
    .output_data(output_data), .tap_last(tap_last), .frame_end(frame_end)
  );

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic              l;
    logic              f;
  } tap_t;

  tap_t exp_q[$];
  int   n_pass = 0, n_total = 0;
  int   taps_seen = 0, lasts_seen = 0, fends_seen = 0;
  bit   stall_en = 0, abort = 0, held = 0;
  logic [DATA_W+1:0] held_v;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic push_frame(input int base);
    tap_t t;
    for (int wr = 0; wr < NWS; wr++)
      for (int wc = 0; wc < NWS; wc++)
        for (int ky = 0; ky < K; ky++)
          for (int kx = 0; kx < K; kx++) begin
            t.d = DATA_W'(base + (wr * STEP + ky) * IMG_W + (wc * STEP + kx));
            t.l = (ky == K - 1) && (kx == K - 1);
            t.f = t.l && (wr == NWS - 1) && (wc == NWS - 1);
            exp_q.push_back(t);
          end
  endtask

  task automatic send_frame(input int base, input bit lat);
    int n;
    push_frame(base);
    for (int idx = 0; idx < IMG_W * IMG_W; idx++) begin
      if (abort) return;
      valid_in   = 1'b1;
      input_data = DATA_W'(base + idx);
      n = 0;
      while (!in_ready && n < 2000 && !abort) begin
        @(negedge clk);
        n++;
      end
      if (abort) return;
      if (n >= 2000) begin
        check("in_ready_timeout", 64'(n), 64'(0));
        valid_in = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      if (lat && idx == (K - 1) * IMG_W + (K - 1)) begin
        check("tap0_latency", 64'(valid_out), 64'(1));
        for (int i = 0; i < K * K; i++) begin
          check("in_ready_low", 64'(in_ready), 64'(0));
          @(posedge clk);
          #1;
        end
        check("in_ready_back", 64'(in_ready), 64'(1));
      end
    end
    valid_in = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || valid_out) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", 64'(exp_q.size()), 64'(0));
  endtask

  // Backpressure generator: random stalls only while stall_en is set.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    tap_t e;
    if (rst_n) begin
      if (held)
        check("stall_hold", 64'({valid_out, output_data, tap_last, frame_end}), 64'({1'b1, held_v}));
      held   = valid_out && !out_ready;
      held_v = {output_data, tap_last, frame_end};
      if (valid_out) check("no_overlap", 64'(in_ready), 64'(0));
      if (valid_out && out_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_tap: got %0h expected none", output_data);
        end else begin
          e = exp_q.pop_front();
          check("tap", 64'({output_data, tap_last, frame_end}), 64'({e.d, e.l, e.f}));
        end
        taps_seen++;
        lasts_seen += int'(tap_last);
        fends_seen += int'(frame_end);
      end
    end else begin
      held = 1'b0;
    end
  end

  initial begin
    int n;
    int taps0;
    rst_n      = 1'b0;
    valid_in   = 1'b0;
    input_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_out", 64'(valid_out), 64'(0));
    check("rst_tap_last", 64'(tap_last), 64'(0));
    check("rst_frame_end", 64'(frame_end), 64'(0));
    check("rst_output_data", 64'(output_data), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(1));

    send_frame(0, 1'b1);
    stall_en = 1'b1;
    send_frame(100, 1'b0);
    drain();
    stall_en = 1'b0;
    check("taps_2frames", 64'(taps_seen), 64'(2 * TPF));
    check("windows_2frames", 64'(lasts_seen), 64'(2 * WPF));
    check("frame_ends_2frames", 64'(fends_seen), 64'(2));

    taps0 = taps_seen;
    fork
      send_frame(0, 1'b0);
      begin
        n = 0;
        do begin
          @(negedge clk);
          #2;
          n++;
        end while (!(valid_out && taps_seen - taps0 == RST_WIN * K * K + 5) && n < 5000);
        check("rst_point_reached", 64'(n < 5000), 64'(1));
        rst_n = 1'b0;
        abort = 1'b1;
        #1;
        check("rst_mid_valid_out", 64'(valid_out), 64'(0));
        check("rst_mid_tap_last", 64'(tap_last), 64'(0));
        check("rst_mid_in_ready", 64'(in_ready), 64'(1));
      end
    join
    valid_in = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    #2;
    rst_n      = 1'b1;
    abort      = 1'b0;
    taps_seen  = 0;
    lasts_seen = 0;
    fends_seen = 0;
    @(posedge clk);
    #1;
    stall_en = 1'b1;
    send_frame(0, 1'b0);
    drain();
    stall_en = 1'b0;
    check("taps_after_rst", 64'(taps_seen), 64'(TPF));
    check("windows_after_rst", 64'(lasts_seen), 64'(WPF));
    check("frame_end_after_rst", 64'(fends_seen), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
